// File: rtl/pe_pkg.sv
// Shared widths and types for the 4-to-2 priority encoder.
package pe_pkg;

  localparam int PE_IN_W  = 4;
  localparam int PE_IDX_W = 2;

  typedef logic [PE_IN_W-1:0]  pe_req_t;
  typedef logic [PE_IDX_W-1:0] pe_idx_t;

  // Index value reported when no request is set; qualify with valid.
  localparam pe_idx_t PE_IDX_NONE = '0;

endpackage : pe_pkg

// File: rtl/pe4to2_comb.sv
// Pure combinational 4-to-2 priority encode core; d[3] wins over all lower bits.
module pe4to2_comb
  import pe_pkg::*;
(
  input  pe_req_t d,
  output pe_idx_t y_n,
  output logic    valid_n
);

  // Priority chain: test the highest bit first so lower bits become don't-care.
  always_comb begin
    y_n     = PE_IDX_NONE;
    valid_n = |d;
    if (d[3])      y_n = 2'd3;
    else if (d[2]) y_n = 2'd2;
    else if (d[1]) y_n = 2'd1;
    else           y_n = 2'd0;
  end

endmodule : pe4to2_comb

// File: rtl/priority_encoder_4to2.sv
// 4-to-2 priority encoder with a one-cycle output register; no comb path d->outputs.
module priority_encoder_4to2
  import pe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    d,
  output logic [1:0]    y,
  output logic          valid
);

  pe_idx_t y_d;
  logic    valid_d;
  pe_idx_t y_q;
  logic    valid_q;

  pe4to2_comb u_core (
    .d       (d),
    .y_n     (y_d),
    .valid_n (valid_d)
  );

  // Output register: reset clears index and valid, otherwise capture the encode.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= PE_IDX_NONE;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

endmodule : priority_encoder_4to2

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench for priority_encoder_4to2 with a threshold-based reference model.
module tb_priority_encoder_4to2;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic [1:0] y;
  logic       valid;

  int checks;
  int errors;
  bit seen [16];

  priority_encoder_4to2 dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Reference: index of the highest set bit, found by magnitude thresholds.
  function automatic int ref_idx(input int v);
    if (v >= 8) return 3;
    if (v >= 4) return 2;
    if (v >= 2) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive d/rst away from the edge, clock once, then check the registered result.
  task automatic tick(input string tag, input logic [3:0] dv, input logic rv);
    int ey;
    int ev;
    @(negedge clk);
    d   = dv;
    rst = rv;
    @(posedge clk);
    #1;
    ey = rv ? 0 : ref_idx(int'(dv));
    ev = rv ? 0 : ((dv != 4'd0) ? 1 : 0);
    chk({tag, "_y"}, int'(y), ey);
    chk({tag, "_valid"}, int'(valid), ev);
  endtask

  initial begin
    int cnt;
    logic [3:0] rv;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    d   = 4'b0000;

    // Reset held for two edges with all requests set, then release.
    tick("rst0", 4'b1111, 1'b1);
    tick("rst1", 4'b1111, 1'b1);
    tick("rel", 4'b1111, 1'b0);
    chk("rel_y_is3", int'(y), 3);

    // Exhaustive sweep.
    for (int i = 0; i < 16; i++) tick($sformatf("sweep%0d", i), 4'(i), 1'b0);

    // Lower bits ignored once a higher bit is set.
    tick("mask0100", 4'b0100, 1'b0);
    tick("mask0111", 4'b0111, 1'b0);
    tick("mask1000", 4'b1000, 1'b0);
    tick("mask1011", 4'b1011, 1'b0);

    // Latency: d changes mid-cycle, outputs hold until the next edge.
    tick("lat0001", 4'b0001, 1'b0);
    d = 4'b0010;
    #2;
    chk("lat_hold_y", int'(y), 0);
    chk("lat_hold_valid", int'(valid), 1);
    @(posedge clk);
    #1;
    chk("lat_next_y", int'(y), 1);

    // Mid-stream reset.
    tick("mid_pre", 4'b1000, 1'b0);
    tick("mid_rst", 4'b1000, 1'b1);
    tick("mid_post", 4'b1000, 1'b0);

    // Independent bit toggles: d[k] flips every 2^k cycles.
    for (int c = 0; c < 32; c++) begin
      for (int k = 0; k < 4; k++) rv[k] = ((c >> k) & 1) != 0;
      seen[rv] = 1'b1;
      tick($sformatf("tog%0d", c), rv, 1'b0);
    end
    cnt = 0;
    for (int i = 0; i < 16; i++) if (seen[i]) cnt++;
    chk("tog_codes_reached", cnt, 16);

    // Random stimulus, including occasional reset.
    for (int c = 0; c < 60; c++) begin
      tick($sformatf("rnd%0d", c), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_priority_encoder_4to2
